// File: rtl/avalon_st_packet_arbiter_if.sv
// avalon_st_if: one Avalon-ST beat bus, parameterised by byte width.
//   data   : 8*DATA_WIDTH_IN_BYTES bits of payload
//   valid  : source presents a beat
//   sop    : first beat of a packet
//   eop    : last beat of a packet
//   empty  : unused bytes in the eop beat, log2up(DATA_WIDTH_IN_BYTES) bits
//   rdy    : sink accepts the beat this cycle
// A beat transfers on a rising clock edge where valid=1 and rdy=1.
// rdy may depend combinationally on valid. A source that raises valid
// keeps the beat stable until it is taken.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_packet_arbiter.sv
// avalon_st_packet_arbiter: merges NUM_INPUTS Avalon-ST streams onto one
// registered output stream. Arbitration is per packet, round-robin, and
// gated by input_enable. A granted input owns the output until its eop
// beat is accepted.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   in_streams[]  : input streams (slave side, rdy driven here)
//   out_stream    : merged output stream (master side, one register stage)
//   input_enable  : bit i=0 blocks new grants to input i
//   grant_idx     : index of the current or last granted input
//   busy          : high while a multi-beat packet is in progress
//   dbg_state_o   : arbiter state (0 idle, 1 locked)
module avalon_st_packet_arbiter #(
  parameter  int NUM_INPUTS          = 4,
  parameter  int DATA_WIDTH_IN_BYTES = 16,
  localparam int IDX_W               = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  avalon_st_if.slave            in_streams [NUM_INPUTS-1:0],
  avalon_st_if.master           out_stream,
  input  logic [NUM_INPUTS-1:0] input_enable,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  busy,
  output logic                  dbg_state_o
);

  localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  // Flattened view of the input interface array so it can be indexed
  // with a run-time grant index.
  logic [DATA_W-1:0]     in_data  [NUM_INPUTS];
  logic [EMPTY_W-1:0]    in_empty [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_sop;
  logic [NUM_INPUTS-1:0] in_eop;
  logic [NUM_INPUTS-1:0] in_rdy;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : gen_in
    assign in_data[g]        = in_streams[g].data;
    assign in_empty[g]       = in_streams[g].empty;
    assign in_valid[g]       = in_streams[g].valid;
    assign in_sop[g]         = in_streams[g].sop;
    assign in_eop[g]         = in_streams[g].eop;
    assign in_streams[g].rdy = in_rdy[g];
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [EMPTY_W-1:0] out_empty_q, out_empty_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;

  logic [NUM_INPUTS-1:0] req;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_req;
  logic                  load;
  logic                  accept;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    if (int'(x) == NUM_INPUTS - 1) return '0;
    return x + 1'b1;
  endfunction

  // Only packet starts on enabled inputs compete for a grant.
  assign req  = in_valid & in_sop & input_enable;
  // The output register can take a new beat when empty or being drained.
  assign load = ~out_valid_q | out_stream.rdy;

  // Round-robin search starting at rr_q, wrapping at NUM_INPUTS.
  always_comb begin
    int j;
    logic [IDX_W-1:0] cand;
    j         = 0;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_INPUTS) j = j - NUM_INPUTS;
      cand = IDX_W'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Selected source: arbitration winner when idle, lock owner when locked.
  always_comb begin
    sel_idx = grant_q;
    sel_req = 1'b1;
    if (state_q == S_IDLE) begin
      sel_idx = win_idx;
      sel_req = win_found;
    end
    in_rdy = '0;
    if (!rst && sel_req) in_rdy[sel_idx] = load;
    accept = in_rdy[sel_idx] & in_valid[sel_idx];
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;

    if (load) begin
      out_valid_d = accept;
      if (accept) begin
        out_sop_d   = in_sop[sel_idx];
        out_eop_d   = in_eop[sel_idx];
        out_empty_d = in_empty[sel_idx];
        out_data_d  = in_data[sel_idx];
      end
    end

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          grant_d = sel_idx;
          // A single-beat packet releases immediately and advances rr.
          if (in_eop[sel_idx]) rr_d = wrap_inc(sel_idx);
          else state_d = S_LOCKED;
        end
        S_LOCKED: begin
          if (in_eop[sel_idx]) begin
            state_d = S_IDLE;
            rr_d    = wrap_inc(grant_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_stream.valid = out_valid_q;
  assign out_stream.sop   = out_sop_q;
  assign out_stream.eop   = out_eop_q;
  assign out_stream.empty = out_empty_q;
  assign out_stream.data  = out_data_q;
  assign grant_idx        = grant_q;
  assign busy             = (state_q == S_LOCKED);
  assign dbg_state_o      = (state_q == S_LOCKED);

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Bench for avalon_st_packet_arbiter: per-input packet sources, a
// packet-level round-robin reference model that fills the expected queue,
// and an output monitor that pops and compares every consumed beat.
module tb_avalon_st_packet_arbiter;
  localparam int N     = 4;
  localparam int DWB   = 16;
  localparam int DW    = 8 * DWB;
  localparam int EW    = 4;
  localparam int IW    = 2;
  localparam int BW    = DW + EW + 2;   // {sop, eop, empty, data}
  localparam int XW    = BW + 4;        // {src, beat}
  localparam int EOP_B = DW + EW;
  localparam int SOP_B = DW + EW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) in_if [N-1:0] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) out_if ();

  logic [N-1:0]  d_valid, d_sop, d_eop, in_rdy_w;
  logic [DW-1:0] d_data  [N];
  logic [EW-1:0] d_empty [N];
  logic          out_rdy;
  logic [N-1:0]  en;
  logic [IW-1:0] grant;
  logic          busy, dbg;

  for (genvar g = 0; g < N; g++) begin : gen_drv
    assign in_if[g].valid = d_valid[g];
    assign in_if[g].sop   = d_sop[g];
    assign in_if[g].eop   = d_eop[g];
    assign in_if[g].data  = d_data[g];
    assign in_if[g].empty = d_empty[g];
    assign in_rdy_w[g]    = in_if[g].rdy;
  end
  assign out_if.rdy = out_rdy;

  avalon_st_packet_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH_IN_BYTES(DWB)) dut (
    .clk(clk), .rst(rst), .in_streams(in_if), .out_stream(out_if),
    .input_enable(en), .grant_idx(grant), .busy(busy), .dbg_state_o(dbg)
  );

  // ---------------- shared state ----------------
  logic [XW-1:0] src_q [N][$];   // beats still to be offered per input
  logic [XW-1:0] mdl_q [N][$];   // model's view of pending packets
  logic [XW-1:0] exp_q [$];      // expected output beats, in order
  int n_vec = 0, n_err = 0;
  int rdy_pct = 100, bub_pct = 0, m_rr = 0, blk_hits = 0, multi_rdy = 0;
  logic          mon_en = 1'b0;
  logic [N-1:0]  blk = '0;
  logic [N-1:0]  acc;
  logic [BW-1:0] acc_beat, prev_acc_beat;
  logic          prev_acc_any;

  task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XW-1:0] mk(input int src, input logic sop, input logic eop,
                                       input logic [EW-1:0] emp, input logic [DW-1:0] d);
    return {4'(src), sop, eop, emp, d};
  endfunction

  task automatic gen_pkt(input int i, input int len, input int emp);
    logic [XW-1:0] w;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[DW-1:DW-8] = 8'(i);
      if (b == len - 1) e = (emp < 0) ? EW'($urandom_range(0, DWB - 1)) : EW'(emp);
      else e = '0;
      w = mk(i, b == 0, b == len - 1, e, d);
      src_q[i].push_back(w);
      mdl_q[i].push_back(w);
    end
  endtask

  // Packet-level reference: whole packets leave in round-robin order among
  // enabled inputs that still hold packets, starting at the model pointer.
  task automatic model_run(input logic [N-1:0] mask);
    int pick;
    int j;
    logic [XW-1:0] w;
    forever begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (pick < 0 && mask[j] && mdl_q[j].size() > 0) pick = j;
      end
      if (pick < 0) break;
      do begin
        w = mdl_q[pick].pop_front();
        exp_q.push_back(w);
      end while (!w[EOP_B]);
      m_rr = (pick + 1) % N;
    end
  endtask

  task automatic clear_all();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
  endtask

  task automatic drain(input string name);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 3000) begin
      @(negedge clk); #3;
      t++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) done = 1'b0;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s drain timeout: %0d beats still expected", name, exp_q.size());
      clear_all();
    end
    repeat (2) @(negedge clk);
    #3;
    chk({name, "_idle_busy"}, XW'(busy), XW'(0));
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; acceptance is sampled just after.
  initial begin : driver
    logic [XW-1:0] w;
    d_valid = '0; d_sop = '0; d_eop = '0; out_rdy = 1'b0;
    acc = '0; acc_beat = '0; prev_acc_any = 1'b0; prev_acc_beat = '0;
    for (int i = 0; i < N; i++) begin
      d_data[i]  = '0;
      d_empty[i] = '0;
    end
    forever begin
      @(negedge clk);
      prev_acc_any  = |acc;
      prev_acc_beat = acc_beat;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && !blk[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (blk[i]) begin
          d_valid[i] = 1'b1; d_sop[i] = 1'b1; d_eop[i] = 1'b1;
          d_data[i] = {DW{1'b1}}; d_empty[i] = '0;
        end else if (src_q[i].size() > 0) begin
          w = src_q[i][0];
          d_sop[i]   = w[SOP_B];
          d_eop[i]   = w[EOP_B];
          d_empty[i] = w[DW+EW-1:DW];
          d_data[i]  = w[DW-1:0];
          // Bubbles only inside packets so the sop timing stays predictable.
          d_valid[i] = w[SOP_B] || ($urandom_range(0, 99) >= bub_pct);
        end else begin
          d_valid[i] = 1'b0;
        end
      end
      out_rdy = ($urandom_range(0, 99) < rdy_pct);
      #1;
      acc = d_valid & in_rdy_w;
      acc_beat = '0;
      for (int i = 0; i < N; i++)
        if (acc[i]) acc_beat = {d_sop[i], d_eop[i], d_empty[i], d_data[i]};
      if ((acc & blk) != '0) blk_hits++;
      if ($countones(in_rdy_w) > 1) multi_rdy++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [BW-1:0] cur, prev_beat;
    logic [XW-1:0] e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_beat = '0;
    forever begin
      @(negedge clk); #2;
      cur = {out_if.sop, out_if.eop, out_if.empty, out_if.data};
      if (mon_en) begin
        if (prev_acc_any)
          chk("latency", {3'b0, out_if.valid, cur}, {4'b0001, prev_acc_beat});
        if (prev_stall)
          chk("stall_stable", {3'b0, out_if.valid, cur}, {4'b0001, prev_beat});
        if (out_if.valid && out_rdy) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", XW'(cur), XW'(e[BW-1:0]));
            if (e[SOP_B]) chk("grant_idx", XW'(grant), XW'(e[XW-1:XW-4]));
            chk("busy", XW'(busy), XW'(!e[EOP_B]));
          end
        end
        prev_stall = out_if.valid && !out_rdy;
        prev_beat  = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin : test
    logic [N-1:0] m;
    int t;
    rst = 1'b1;
    en = '1;
    blk[0] = 1'b1;                 // a live request that reset must block
    repeat (3) @(negedge clk);
    #3;
    chk("rst_rdy",   XW'(in_rdy_w),     XW'(0));
    chk("rst_valid", XW'(out_if.valid), XW'(0));
    chk("rst_busy",  XW'(busy),         XW'(0));
    chk("rst_grant", XW'(grant),        XW'(0));
    chk("rst_state", XW'(dbg),          XW'(0));
    blk[0] = 1'b0;
    @(negedge clk); #3;
    rst = 1'b0;
    mon_en = 1'b1;

    // contention from rr=0: inputs 0,1,3 with 2-beat packets
    gen_pkt(0, 2, -1); gen_pkt(1, 2, -1); gen_pkt(3, 2, -1);
    model_run(en);
    drain("contention");

    // single input 2, 3 beats, empty=5
    gen_pkt(2, 3, 5);
    model_run(en);
    drain("single");

    // backpressure on a 4-beat packet
    rdy_pct = 50;
    gen_pkt(1, 4, -1);
    model_run(en);
    drain("backpressure");
    rdy_pct = 100;

    // single-beat packets from 0 and 1 alternate
    for (int k = 0; k < 4; k++) begin
      gen_pkt(0, 1, -1);
      gen_pkt(1, 1, -1);
    end
    model_run(en);
    drain("single_beat");

    // mask: input 1 blocked, input 2 granted; drop bit 2 mid-packet
    en = 4'b1101;
    blk[1] = 1'b1;
    blk_hits = 0;
    gen_pkt(2, 4, -1);
    model_run(en);
    t = 0;
    while (!(out_if.valid && out_if.sop) && t < 50) begin
      @(negedge clk); #3;
      t++;
    end
    en = 4'b1001;
    drain("mask");
    chk("masked_input_rdy", XW'(blk_hits), XW'(0));
    blk = '0;
    @(negedge clk); #3;
    en = '1;

    // reset during beat 1 of a 4-beat packet
    gen_pkt(1, 4, -1);
    model_run(en);
    t = 0;
    while (!(out_if.valid && out_if.sop) && t < 50) begin
      @(negedge clk); #3;
      t++;
    end
    @(negedge clk); #3;
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk); #3;
    chk("midrst_valid", XW'(out_if.valid), XW'(0));
    chk("midrst_rdy",   XW'(in_rdy_w),     XW'(0));
    chk("midrst_busy",  XW'(busy),         XW'(0));
    chk("midrst_grant", XW'(grant),        XW'(0));
    clear_all();
    m_rr = 0;
    rst = 1'b0;
    @(negedge clk); #3;
    mon_en = 1'b1;
    gen_pkt(3, 3, -1);
    model_run(en);
    drain("after_reset");

    // randomized phases
    blk_hits = 0;
    for (int p = 0; p < 30; p++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      en = m;
      rdy_pct = (p % 3 == 0) ? 100 : ((p % 3 == 1) ? 70 : 40);
      bub_pct = (p % 2 == 0) ? 0 : 20;
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          int np;
          np = $urandom_range(0, 3);
          for (int k = 0; k < np; k++) gen_pkt(i, $urandom_range(1, 5), -1);
        end else begin
          blk[i] = 1'($urandom_range(0, 1));
        end
      end
      model_run(m);
      drain("random");
      blk = '0;
      @(negedge clk); #3;
    end
    chk("random_masked_rdy", XW'(blk_hits), XW'(0));
    chk("one_hot_rdy", XW'(multi_rdy), XW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_st_packet_arbiter.md
Name: avalon_st_packet_arbiter

Overview:
- Shares one Avalon-ST output stream between NUM_INPUTS Avalon-ST input streams.
- Arbitration is packet-granular, round-robin and mask-gated.
- Once an input is granted on its sop beat, it owns the output until its eop beat is accepted.
- Sits upstream of the avalon enforcer / downstream consumers, merging several packet sources onto one bus through a single registered output stage.

Parameters:
- NUM_INPUTS, 4, number of input streams (2..16).
- DATA_WIDTH_IN_BYTES, 16, byte width of every stream. Forwarded to all avalon_st_if instances; empty width is log2up_func(DATA_WIDTH_IN_BYTES).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_streams  avalon_st_if.slave  [NUM_INPUTS-1:0]  input streams (data, valid, sop, eop, empty in; rdy out).
- out_stream  avalon_st_if.master  1  merged output stream (data, valid, sop, eop, empty out; rdy in).
- input_enable  input  NUM_INPUTS  per-input arbitration enable mask; bit i=0 blocks new grants to input i.
- grant_idx  output  log2up_func(NUM_INPUTS)  index of the current or last granted input.
- busy  output  1  high while a multi-beat packet is in progress (LOCKED).

Behaviour:
Reset:
- Synchronous, active-high: reset acts on a rising clk edge while rst=1.
- After that edge: out_stream.valid/sop/eop=0, data=0, empty=0, grant_idx=0, busy=0, rr pointer=0, state=IDLE.
- All in_streams[i].rdy=0 while rst=1.
- Reset mid-packet discards the packet: no eop is emitted and the output register clears.

Output stage:
- One registered beat. load = ~out_stream.valid | out_stream.rdy.
- Latency: an accepted input beat appears on out_stream the next cycle.
- On load with an accepted beat: register captures data/sop/eop/empty, valid=1.
- On load with no accepted beat: valid=0; data/sop/eop/empty are don't-care but hold their values.
- While valid=1 and rdy=0: all output fields hold stable.
- Full throughput: one beat per cycle when out_stream.rdy=1 continuously.

Request:
- req[i] = in_streams[i].valid & in_streams[i].sop & input_enable[i].

State IDLE:
- Winner = first i with req[i]=1, searching from rr pointer upward with wrap (rr, rr+1, ..., NUM_INPUTS-1, 0, ...).
- in_streams[winner].rdy = load. All other rdy=0.
- If no req: all rdy=0, state holds.
- Accepted sop beat with eop=0: state->LOCKED, grant_idx=winner, busy=1.
- Accepted beat with sop=1 and eop=1 (single-beat packet): stay IDLE, grant_idx=winner, rr=winner+1 mod NUM_INPUTS.
- If winner is not accepted (load=0): nothing latched. Arbitration re-evaluates next cycle; the winner may change.

State LOCKED:
- in_streams[grant_idx].rdy = load. All other rdy=0.
- Beats are forwarded regardless of their sop value.
- input_enable changes do not affect the locked packet.
- Accepted eop beat: state->IDLE, busy=0, rr=grant_idx+1 mod NUM_INPUTS, grant_idx holds.
- The next grant can be accepted in the cycle after eop acceptance (one idle arbitration cycle minimum is not required; back-to-back packets from different inputs with zero bubble are NOT required either).
- A new grant is issued only from IDLE, so there is at least one cycle between an eop acceptance and the next sop acceptance.
- Granted input valid=0 mid-packet: the output produces a bubble (valid=0) and the lock holds.

Protocol rules:
- Non-sop beats on a non-granted input are never requesters and stall (rdy=0) indefinitely.
- An input that asserts sop while already locked is forwarded as data. The arbiter does not check framing; the downstream enforcer does.
- empty passes unmodified.
- Simultaneous requests resolve by round-robin only; no fixed priority except after reset (rr=0).

Test Plan:
1. Single input: input 2 sends a 3-beat packet (sop beat0, eop beat2, empty=5) with out rdy=1 -> out shows the 3 beats 1 cycle delayed, sop/eop/empty=5 intact, busy=1 for beats 0-1, grant_idx=2.
2. Contention: inputs 0,1,3 each hold a 2-beat packet valid from cycle 0, rr=0 -> output order is packets 0,1,3; no beat interleaving; rr ends at 0 (3+1 mod 4).
3. Backpressure: out rdy toggles 1,0,0,1 during a 4-beat packet -> out fields stable while rdy=0; granted in rdy=0 in those cycles; all 4 beats delivered in order, no duplication.
4. Mask: input_enable=4'b1101 with inputs 1 and 2 requesting -> input 2 granted, input 1 stays rdy=0. Clearing bit 2 mid-packet -> input 2's packet completes; input 1 remains blocked.
5. Single-beat packets: inputs 0 and 1 continuously send sop=eop=1 beats -> grants alternate 0,1,0,1; busy stays 0.
6. Reset mid-packet: assert rst during beat 1 of a 4-beat packet -> the next cycle shows out valid=0, all rdy=0, busy=0, grant_idx=0; after rst release, a new sop from input 3 is granted normally.
